// File: rtl/game_pkg.sv
// game_pkg: shared FSM state encoding, keycodes and helpers for the game flow controller.
package game_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PLAY    = 3'd1,
    EXPLODE = 3'd2,
    RESPAWN = 3'd3,
    OVER    = 3'd4
  } game_state_t;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction
endpackage

// File: rtl/game_flow_ctrl_frame_timer.sv
// frame_timer: loadable per-frame down-counter with a zero flag; load wins over decrement.
module frame_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: frame-rate game FSM (idle/play/explode/respawn/over) with lives, score and invulnerability.
// Define HIGH_SCORE_EN to add a hi_score output latched on entry to OVER.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int LIVES_INIT     = 3,
  parameter int EXPLODE_FRAMES = 30,
  parameter int INVULN_FRAMES  = 90
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [24:0] keycode,
  input  logic        ship_hit,
  input  logic [3:0]  enemy_pass,
  output logic        ship_rst,
  output logic        spawn_en,
  output logic        invuln,
  output logic [1:0]  lives,
  output logic [15:0] score,
  output logic [2:0]  game_state,
  output logic [4:0]  explode_cnt
`ifdef HIGH_SCORE_EN
  ,
  output logic [15:0] hi_score
`endif
);
  game_state_t state, next;
  logic        key_prev, enter_now, start_key;
  logic        game_start, hit_now, exp_zero, inv_zero;
  logic [4:0]  exp_left;
  logic [7:0]  inv_left;
  logic [16:0] sum;
  logic        key_unused;
  assign key_unused = &{1'b1, keycode[24]};
  assign enter_now  = (keycode[7:0] == KEY_ENTER) | (keycode[15:8] == KEY_ENTER) | (keycode[23:16] == KEY_ENTER);
  assign start_key  = enter_now & ~key_prev;
  assign hit_now    = ship_hit & ~invuln;
  assign game_start = (state == IDLE) & (next == PLAY);
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = start_key ? PLAY : IDLE;
      PLAY:    next = hit_now ? EXPLODE : PLAY;
      EXPLODE: next = !exp_zero ? EXPLODE : (lives == 2'd0 ? OVER : RESPAWN);
      RESPAWN: next = PLAY;
      OVER:    next = start_key ? IDLE : OVER;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge frame_clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= next;
  frame_timer #(.W(5)) u_explode (
    .clk(frame_clk), .rst(Reset),
    .load((state == PLAY) & hit_now), .load_val(5'(EXPLODE_FRAMES - 1)),
    .dec(state == EXPLODE), .cnt(exp_left), .zero(exp_zero)
  );
  frame_timer #(.W(8)) u_invuln (
    .clk(frame_clk), .rst(Reset),
    .load(state == RESPAWN), .load_val(8'(INVULN_FRAMES)),
    .dec(state == PLAY), .cnt(inv_left), .zero(inv_zero)
  );
  assign sum = {1'b0, score} + 17'(popcount4(enemy_pass));
  // key history resets to "pressed" so a key held across reset never counts as a new press
  always_ff @(posedge frame_clk or posedge Reset)
    if (Reset) begin
      key_prev <= 1'b1;
      lives    <= '0;
      score    <= '0;
      ship_rst <= 1'b0;
    end else begin
      key_prev <= enter_now;
      ship_rst <= game_start | (next == RESPAWN);
      if (game_start) begin
        lives <= 2'(LIVES_INIT);
        score <= '0;
      end else if (state == PLAY) begin
        score <= sum[16] ? 16'hFFFF : sum[15:0];
        if (hit_now && lives != 2'd0) lives <= lives - 2'd1;
      end
    end
`ifdef HIGH_SCORE_EN
  always_ff @(posedge frame_clk or posedge Reset)
    if (Reset) hi_score <= '0;
    else if (state == EXPLODE && next == OVER && score > hi_score) hi_score <= score;
`endif
  assign spawn_en    = state == PLAY;
  assign invuln      = ~inv_zero;
  assign game_state  = state;
  assign explode_cnt = (state == EXPLODE) ? 5'(EXPLODE_FRAMES - 1) - exp_left : 5'd0;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed self-checking bench for game_flow_ctrl (add HIGH_SCORE_EN to cover hi_score).
module tb_game_flow_ctrl;
  import game_pkg::*;
  localparam int EF = 30;
  localparam int IF = 90;
  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [24:0] keycode;
  logic        ship_hit;
  logic [3:0]  enemy_pass;
  logic        ship_rst, spawn_en, invuln;
  logic [1:0]  lives;
  logic [15:0] score;
  logic [2:0]  game_state;
  logic [4:0]  explode_cnt;
`ifdef HIGH_SCORE_EN
  logic [15:0] hi_score;
`endif
  int n_chk = 0;
  int n_pass = 0;
  game_flow_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .ship_hit(ship_hit),
    .enemy_pass(enemy_pass), .ship_rst(ship_rst), .spawn_en(spawn_en), .invuln(invuln),
    .lives(lives), .score(score), .game_state(game_state), .explode_cnt(explode_cnt)
`ifdef HIGH_SCORE_EN
    , .hi_score(hi_score)
`endif
  );
  always #5 frame_clk = ~frame_clk;
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge frame_clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic chk_state(input string tag, input game_state_t exp);
    chk(tag, 32'(game_state), 32'(exp));
  endtask
  initial begin
    Reset = 1'b1; keycode = 25'h28; ship_hit = 1'b0; enemy_pass = 4'd0;
    tick(2);
    chk_state("rst_state", IDLE);
    chk("rst_lives", 32'(lives), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_ship_rst", 32'(ship_rst), 0);
    chk("rst_spawn", 32'(spawn_en), 0);
    chk("rst_invuln", 32'(invuln), 0);
    chk("rst_explode_cnt", 32'(explode_cnt), 0);
    Reset = 1'b0;
    tick(3);
    chk_state("held_through_reset", IDLE);
    keycode = 25'd0; tick(1);
    keycode = 25'h1002800; tick(1);
    chk_state("start_state", PLAY);
    chk("start_lives", 32'(lives), 3);
    chk("start_score", 32'(score), 0);
    chk("start_ship_rst", 32'(ship_rst), 1);
    chk("start_spawn", 32'(spawn_en), 1);
    chk("start_invuln", 32'(invuln), 0);
    keycode = 25'd0; tick(1);
    chk("ship_rst_one_frame", 32'(ship_rst), 0);
    enemy_pass = 4'b1011; tick(1);
    chk("score_add3", 32'(score), 3);
    ship_hit = 1'b1; enemy_pass = 4'b0011; tick(1);
    chk("simul_score", 32'(score), 5);
    chk_state("simul_explode", EXPLODE);
    chk("hit1_lives", 32'(lives), 2);
    chk("explode_spawn_off", 32'(spawn_en), 0);
    chk("explode_cnt_first", 32'(explode_cnt), 0);
    ship_hit = 1'b0; enemy_pass = 4'hF; tick(EF - 1);
    chk_state("explode_last_state", EXPLODE);
    chk("explode_cnt_last", 32'(explode_cnt), 29);
    chk("explode_ignores_pass", 32'(score), 5);
    enemy_pass = 4'd0; tick(1);
    chk_state("respawn_state", RESPAWN);
    chk("respawn_ship_rst", 32'(ship_rst), 1);
    tick(1);
    chk_state("respawn_to_play", PLAY);
    chk("play_invuln_on", 32'(invuln), 1);
    chk("play_ship_rst_off", 32'(ship_rst), 0);
    ship_hit = 1'b1; tick(IF - 1);
    chk_state("invuln_hit_ignored", PLAY);
    chk("invuln_last_frame", 32'(invuln), 1);
    chk("invuln_lives", 32'(lives), 2);
    tick(1);
    chk("invuln_expired", 32'(invuln), 0);
    chk_state("invuln_expired_state", PLAY);
    tick(1);
    chk_state("hit2_state", EXPLODE);
    chk("hit2_lives", 32'(lives), 1);
    ship_hit = 1'b0; tick(EF + 1 + IF);
    ship_hit = 1'b1; tick(1);
    ship_hit = 1'b0;
    chk("hit3_lives", 32'(lives), 0);
    keycode = 25'h28; tick(EF);
    chk_state("over_state", OVER);
    chk("over_lives", 32'(lives), 0);
    chk("over_score", 32'(score), 5);
    tick(3);
    chk_state("over_enter_held", OVER);
    keycode = 25'd0; tick(1);
    keycode = 25'h28; tick(1);
    chk_state("over_to_idle", IDLE);
    chk("idle_score_hold", 32'(score), 5);
`ifdef HIGH_SCORE_EN
    chk("hi_after_game1", 32'(hi_score), 5);
`endif
    keycode = 25'd0; tick(1);
    keycode = 25'h28; tick(1);
    chk_state("game2_start", PLAY);
    chk("game2_score_clear", 32'(score), 0);
    keycode = 25'd0; enemy_pass = 4'b0111; tick(1);
    enemy_pass = 4'd0;
    chk("game2_score", 32'(score), 3);
    for (int i = 0; i < 3; i++) begin
      ship_hit = 1'b1; tick(1);
      ship_hit = 1'b0; tick(EF);
      if (i < 2) tick(1 + IF);
    end
    chk_state("game2_over", OVER);
`ifdef HIGH_SCORE_EN
    chk("hi_after_game2", 32'(hi_score), 5);
`endif
    keycode = 25'h28; tick(1);
    chk_state("game2_to_idle", IDLE);
    keycode = 25'd0; tick(1);
    keycode = 25'h28; tick(1);
    keycode = 25'd0;
    chk_state("game3_start", PLAY);
    enemy_pass = 4'hF; tick(16383);
    chk("sat_pre", 32'(score), 32'hFFFC);
    enemy_pass = 4'b0011; tick(1);
    chk("sat_fffe", 32'(score), 32'hFFFE);
    tick(1);
    chk("sat_ffff", 32'(score), 32'hFFFF);
    enemy_pass = 4'hF; tick(1);
    chk("sat_hold", 32'(score), 32'hFFFF);
    enemy_pass = 4'd0;
    ship_hit = 1'b1; tick(1);
    ship_hit = 1'b0; tick(9);
    chk_state("mid_explode_state", EXPLODE);
    chk("mid_explode_cnt", 32'(explode_cnt), 9);
    keycode = 25'h28; Reset = 1'b1; #1;
    chk_state("async_rst_state", IDLE);
    chk("async_rst_lives", 32'(lives), 0);
    chk("async_rst_score", 32'(score), 0);
    chk("async_rst_cnt", 32'(explode_cnt), 0);
    chk("async_rst_spawn", 32'(spawn_en), 0);
    chk("async_rst_invuln", 32'(invuln), 0);
    chk("async_rst_ship_rst", 32'(ship_rst), 0);
`ifdef HIGH_SCORE_EN
    chk("async_rst_hi", 32'(hi_score), 0);
`endif
    tick(2);
    Reset = 1'b0; tick(3);
    chk_state("rst_enter_held_idle", IDLE);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameter LIVES_INIT, default 3, lives granted at game start (1..3).
REQ-002 Parameter EXPLODE_FRAMES, default 30, frames spent in EXPLODE.
REQ-003 Parameter INVULN_FRAMES, default 90, frames of post-respawn invulnerability.
REQ-004 frame_clk  in  1  sole clock, one edge per video frame.
REQ-005 Reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
REQ-006 keycode  in  25  three USB keycode bytes in [23:0]; bit 24 ignored.
REQ-007 ship_hit  in  1  level from the ship collision logic; high = ship overlaps a live enemy.
REQ-008 enemy_pass  in  4  one-frame pulse per enemy slot leaving the screen undestroyed.
REQ-009 ship_rst  out  1  recentres the ship datapath; high for exactly one frame.
REQ-010 spawn_en  out  1  enemy generator enable.
REQ-011 invuln  out  1  collisions ignored; sprite blinks.
REQ-012 lives  out  2  remaining lives.
REQ-013 score  out  16  current score.
REQ-014 game_state  out  3  encoded FSM state, for the display mux.
REQ-015 explode_cnt  out  5  EXPLODE frame index 0..EXPLODE_FRAMES-1, for the animation ROM.

Function
REQ-016 States: IDLE, PLAY, EXPLODE, RESPAWN, OVER; all other transitions are forbidden.
REQ-017 start_key = rising edge (across frames) of "any keycode byte == 8'h28". A key held through a reset or a state change SHALL NOT start a game.
REQ-018 IDLE->PLAY on start_key: lives<=LIVES_INIT, score<=0, ship_rst=1 for that one frame.
REQ-019 PLAY->EXPLODE on ship_hit while invuln=0: lives decrements in the same edge; spawn_en drops on entry.
REQ-020 EXPLODE lasts exactly EXPLODE_FRAMES frames (explode_cnt counts 0 up to the max); on the last frame, go to OVER if lives==0, otherwise to RESPAWN.
REQ-021 RESPAWN lasts one frame: ship_rst=1, the invulnerability timer loads INVULN_FRAMES, next state is PLAY.
REQ-022 invuln=1 while the timer is nonzero; the timer decrements once per PLAY frame; ship_hit is ignored while invuln=1.
REQ-023 OVER->IDLE on start_key; score holds its value through OVER and IDLE until the next game starts.
REQ-024 spawn_en=1 only in PLAY.
REQ-025 Score: in PLAY, add popcount(enemy_pass) each frame; saturate at 16'hFFFF with no wrap; enemy_pass is ignored outside PLAY.
REQ-026 Simultaneous events: if ship_hit and enemy_pass occur in the same PLAY frame, the score add happens and then EXPLODE is entered.
REQ-027 lives SHALL never underflow below 0.

Reset
REQ-028 Reset SHALL force the following at any time, including mid-EXPLODE: state=IDLE, lives=0, score=0, ship_rst=0, spawn_en=0, invuln=0, explode_cnt=0, timers=0, key-edge history=pressed.
REQ-029 After Reset deasserts, a new key press is needed before leaving IDLE.

Configuration
REQ-030 With HIGH_SCORE_EN defined:
- an added output hi_score[15:0] latches score on entry to OVER when score exceeds hi_score;
- hi_score is cleared only by Reset.
REQ-031 Without HIGH_SCORE_EN, no hi_score port or register exists; all other behaviour is identical.

Structure
REQ-032 Package game_pkg SHALL hold:
- the state enum game_state_t (3-bit);
- KEY_ENTER=8'h28, plus the KEY_A/D/W/S codes shared with the ship datapath.
REQ-033 One sub-module, frame_timer:
- loadable down-counter with zero flag;
- instantiated twice, for explode and invuln.

Verification
REQ-034 Reset, then Enter pressed for 1 frame -> next frame: PLAY, lives=3, score=0, ship_rst high for exactly 1 frame, spawn_en=1.
REQ-035 PLAY, enemy_pass=4'b1011 for 1 frame -> score +3; preload score=16'hFFFE with enemy_pass=4'b0011 -> score=16'hFFFF.
REQ-036 PLAY, ship_hit for 1 frame -> lives=2, EXPLODE for 30 frames, RESPAWN 1 frame with ship_rst=1, PLAY with invuln=1 for 90 frames; ship_hit held during invuln -> no state change.
REQ-037 Three hits -> after the third EXPLODE the FSM enters OVER with lives=0; Enter held continuously -> FSM stays OVER; release then press -> IDLE.
REQ-038 Reset asserted in the 10th EXPLODE frame -> IDLE with all outputs at reset values; Enter still held at deassert -> FSM stays IDLE.
REQ-039 HIGH_SCORE_EN: game 1 ends with score 5 and game 2 ends with score 3 -> hi_score=5 after both games.
